c1_feeder: RTL and testbench
============================

# c1_feeder

Sequencer that drives the first convolution layer's processing unit. On `start` it fetches per-output-channel weight, bias and shift from a parameter ROM, streams every input-feature-map pixel from a synchronous RAM, and presents them as a valid-qualified stream on the unit's `input_vld`/`input_din`/`weight_din`/`bias_din`/`shift_din` inputs. It sits between the feature-map buffer and the layer-1 conv unit and owns all address generation for that layer.

## Interface
- `N`, 16: data width of pixels and weights.
- `IMG_SIZE`, 28: input image side length, in pixels.
- `OUT_CH`, 6: number of output channels, processed sequentially.
- `TAIL_CYCLES`, 4: cycles that weight/bias/shift stay held after a channel's last `input_vld`. Covers the conv unit pipeline.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `start` in 1: one-cycle request to process the layer. Ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse when the last channel's tail completes.
- `fmap_rd_en` out 1: feature RAM read strobe.
- `fmap_rd_addr` out `$clog2(IMG_SIZE*IMG_SIZE)`: row-major pixel address.
- `fmap_rd_data` in N: RAM data, valid the cycle after `fmap_rd_en`.
- `param_rd_en` out 1: parameter ROM read strobe.
- `param_rd_addr` out `$clog2(OUT_CH)` (min 1): channel index.
- `weight_rd_data` in N, `bias_rd_data` in 32, `shift_rd_data` in 5: ROM data, valid the cycle after `param_rd_en`.
- `input_vld` out 1: pixel valid to the conv unit.
- `input_din` out N: pixel to the conv unit.
- `weight_din` out N, `bias_din` out 32, `shift_din` out 5: current channel parameters, registered.

## Operation
- Reset state: FSM in IDLE. All outputs are 0: `busy`, `done`, both read enables, both addresses, `input_vld`, `input_din`, `weight_din`, `bias_din`, `shift_din`.
- FSM states: IDLE, PARAM_RD, PARAM_CAP, STREAM, TAIL, DONE.
- IDLE:
  - `start`=1 → PARAM_RD.
  - Channel counter `ch` = 0.
- PARAM_RD:
  - `param_rd_en`=1, `param_rd_addr`=`ch`.
  - → PARAM_CAP.
- PARAM_CAP:
  - Register `weight_din`/`bias_din`/`shift_din` from the ROM data.
  - Clear the pixel counter `pix`.
  - → STREAM.
- STREAM:
  - One position per cycle, no gaps.
  - For a real pixel: `fmap_rd_en`=1, `fmap_rd_addr`=`pix`.
  - After the last position is issued → TAIL.
- TAIL:
  - Count `TAIL_CYCLES` cycles, starting from the cycle after the last `input_vld`.
  - Then, if `ch`<`OUT_CH`-1: increment `ch`, → PARAM_RD.
  - Otherwise → DONE.
- DONE:
  - `done`=1 for one cycle; `busy` drops the following cycle.
  - → IDLE.
- Parameters change only in PARAM_CAP. Between a channel's first `input_vld` and the end of its TAIL they are constant.
- `input_vld`/`input_din` are registered from the delayed read strobe and `fmap_rd_data`. `input_din`=0 whenever `input_vld`=0.
- Address arithmetic is unsigned. `pix` wraps to 0 only through PARAM_CAP, never by overflow.
- Reset asserted mid-operation: immediate return to reset values. No partial `done`. In-flight RAM data is discarded.
- `start` while `busy`: no effect. `start` in the DONE cycle: ignored.

## Timing
- `fmap_rd_en` at cycle T → `input_vld` at T+2 (RAM latency 1, output register 1).
- `param_rd_en` at T → parameters visible on outputs at T+2.
- `param_rd_en` at T → first `fmap_rd_en` at T+2.
- Per-channel cycle count: 2 + P + 1 + `TAIL_CYCLES`, where P is the number of positions streamed.
  - The +1 is the last-issue-to-last-valid register stage.
- `start` at cycle S: `busy` rises at S+1; `done` arrives at S+1+`OUT_CH`×(per-channel count).

## Configuration
- `C1_FEEDER_PADDING_EN` defined:
  - Each channel streams (IMG_SIZE+2)² positions.
  - Border positions (row or column index 0 or IMG_SIZE+1) emit `input_vld`=1 with `input_din`=0 and no RAM read.
  - Interior positions read address (r-1)×IMG_SIZE+(c-1).
  - Output order is row-major over the padded grid.
- Undefined: IMG_SIZE² positions, every one a RAM read; no padding logic synthesized.

## Test plan
- Reset values: hold `rst_n`=0 with `start`=1 → every output 0, no read enables.
- Basic run, IMG_SIZE=4, OUT_CH=2, TAIL_CYCLES=4, RAM[i]=i+1, ROM ch0={w=3,b=10,s=2}, ch1={w=5,b=20,s=1}:
  - `input_vld` count 16 per channel; `input_din` sequence 1..16, twice.
  - Parameters at each `input_vld` match that channel's ROM entry.
  - `done` at S+1+2×(2+16+1+4) = S+47.
- Back-to-back `start` at S and at S+5 → second ignored, single `done`.
- Reset at cycle 10 of a channel's STREAM → outputs 0 within the same cycle. A new `start` after release restarts at `ch`=0, pixel 0.
- With `C1_FEEDER_PADDING_EN`, IMG_SIZE=4:
  - 36 valids per channel.
  - Positions 0–6 are zero with no `fmap_rd_en`; position 7 is RAM[0]=1.
  - 16 RAM reads per channel.
- Parameter stability: ROM changes its output on every cycle of the run → parameter outputs change only in cycles after a PARAM_CAP.

Source files
------------

// File: rtl/c1_feeder_if.sv
// Feature-RAM read port, parameter-ROM read port and conv-unit stream for the layer-1 feeder.
// master = feeder side, slave = environment (RAM, ROM, conv unit, controller).
interface c1_feeder_if #(
  parameter int N        = 16,
  parameter int IMG_SIZE = 28,
  parameter int OUT_CH   = 6
);
  localparam int AW = $clog2(IMG_SIZE * IMG_SIZE);
  localparam int CW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  logic          start;
  logic          busy;
  logic          done;
  logic          fmap_rd_en;
  logic [AW-1:0] fmap_rd_addr;
  logic [N-1:0]  fmap_rd_data;
  logic          param_rd_en;
  logic [CW-1:0] param_rd_addr;
  logic [N-1:0]  weight_rd_data;
  logic [31:0]   bias_rd_data;
  logic [4:0]    shift_rd_data;
  logic          input_vld;
  logic [N-1:0]  input_din;
  logic [N-1:0]  weight_din;
  logic [31:0]   bias_din;
  logic [4:0]    shift_din;

  modport master (
    input  start, fmap_rd_data, weight_rd_data, bias_rd_data, shift_rd_data,
    output busy, done, fmap_rd_en, fmap_rd_addr, param_rd_en, param_rd_addr,
           input_vld, input_din, weight_din, bias_din, shift_din
  );

  modport slave (
    output start, fmap_rd_data, weight_rd_data, bias_rd_data, shift_rd_data,
    input  busy, done, fmap_rd_en, fmap_rd_addr, param_rd_en, param_rd_addr,
           input_vld, input_din, weight_din, bias_din, shift_din
  );
endinterface

// File: rtl/c1_feeder.sv
// Layer-1 conv sequencer: per channel fetch params, stream the fmap (2-cycle pixel latency, no backpressure),
// hold params through a tail. `C1_FEEDER_PADDING_EN streams a zero border around the image.
module c1_feeder #(
  parameter int N           = 16,
  parameter int IMG_SIZE    = 28,
  parameter int OUT_CH      = 6,
  parameter int TAIL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  c1_feeder_if.master io
);
  localparam int NPIX = IMG_SIZE * IMG_SIZE;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int TW   = $clog2(TAIL_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_PARAM_RD, S_PARAM_CAP, S_STREAM, S_TAIL, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [N-1:0]  weight_q, weight_d;
  logic [31:0]   bias_q, bias_d;
  logic [4:0]    shift_q, shift_d;
  logic          issue_q, issue_d;
  logic          input_vld_q, input_vld_d;
  logic [N-1:0]  input_din_q, input_din_d;
  logic          last_pos, real_rd, last_ch, tail_done;
  logic [AW-1:0] pos_addr;

`ifdef C1_FEEDER_PADDING_EN
  localparam int GRID = IMG_SIZE + 2;
  localparam int RW   = $clog2(GRID);

  logic [RW-1:0] row_q, row_d, col_q, col_d;
  logic          pad_q, pad_d;

  // Walk the padded grid; only interior positions map onto RAM addresses.
  always_comb begin
    real_rd  = (row_q != '0) && (col_q != '0) &&
               (row_q != RW'(GRID - 1)) && (col_q != RW'(GRID - 1));
    last_pos = (row_q == RW'(GRID - 1)) && (col_q == RW'(GRID - 1));
    pos_addr = AW'((32'(row_q) - 32'd1) * 32'(IMG_SIZE) + 32'(col_q) - 32'd1);
    row_d    = row_q;
    col_d    = col_q;
    if (state_q == S_PARAM_CAP) begin
      row_d = '0;
      col_d = '0;
    end else if (state_q == S_STREAM && !last_pos) begin
      if (col_q == RW'(GRID - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    pad_d = (state_q == S_STREAM) && !real_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      pad_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      pad_q <= pad_d;
    end
  end
`else
  logic [AW-1:0] pix_q, pix_d;

  always_comb begin
    real_rd  = 1'b1;
    last_pos = (pix_q == AW'(NPIX - 1));
    pos_addr = pix_q;
    pix_d    = pix_q;
    if (state_q == S_PARAM_CAP) begin
      pix_d = '0;
    end else if (state_q == S_STREAM && !last_pos) begin
      pix_d = pix_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end
`endif

  assign last_ch   = (ch_q == CW'(OUT_CH - 1));
  assign tail_done = (tail_q == TW'(TAIL_CYCLES));

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (io.start) state_d = S_PARAM_RD;
      S_PARAM_RD:  state_d = S_PARAM_CAP;
      S_PARAM_CAP: state_d = S_STREAM;
      S_STREAM:    if (last_pos) state_d = S_TAIL;
      S_TAIL:      if (tail_done) state_d = last_ch ? S_DONE : S_PARAM_RD;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Counters, parameter capture and the two-stage pixel pipeline
  always_comb begin
    ch_d     = ch_q;
    tail_d   = tail_q;
    weight_d = weight_q;
    bias_d   = bias_q;
    shift_d  = shift_q;
    unique case (state_q)
      S_IDLE: ch_d = '0;
      S_PARAM_CAP: begin
        weight_d = io.weight_rd_data;
        bias_d   = io.bias_rd_data;
        shift_d  = io.shift_rd_data;
        tail_d   = '0;
      end
      S_TAIL: begin
        tail_d = tail_q + 1'b1;
        if (tail_done && !last_ch) ch_d = ch_q + 1'b1;
      end
      default: ;
    endcase
    issue_d     = (state_q == S_STREAM);
    input_vld_d = issue_q;
`ifdef C1_FEEDER_PADDING_EN
    input_din_d = (issue_q && !pad_q) ? io.fmap_rd_data : '0;
`else
    input_din_d = issue_q ? io.fmap_rd_data : '0;
`endif
  end

  // Outputs decoded from state
  always_comb begin
    io.busy          = (state_q != S_IDLE);
    io.done          = (state_q == S_DONE);
    io.param_rd_en   = (state_q == S_PARAM_RD);
    io.param_rd_addr = (state_q == S_PARAM_RD) ? ch_q : '0;
    io.fmap_rd_en    = (state_q == S_STREAM) && real_rd;
    io.fmap_rd_addr  = ((state_q == S_STREAM) && real_rd) ? pos_addr : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      tail_q      <= '0;
      weight_q    <= '0;
      bias_q      <= '0;
      shift_q     <= '0;
      issue_q     <= 1'b0;
      input_vld_q <= 1'b0;
      input_din_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      tail_q      <= tail_d;
      weight_q    <= weight_d;
      bias_q      <= bias_d;
      shift_q     <= shift_d;
      issue_q     <= issue_d;
      input_vld_q <= input_vld_d;
      input_din_q <= input_din_d;
    end
  end

  assign io.input_vld  = input_vld_q;
  assign io.input_din  = input_din_q;
  assign io.weight_din = weight_q;
  assign io.bias_din   = bias_q;
  assign io.shift_din  = shift_q;
endmodule

// File: tb/tb_c1_feeder.sv
// Directed bench for c1_feeder at IMG_SIZE=4, OUT_CH=2, TAIL_CYCLES=4, RAM[i]=i+1.
// Expectations follow C1_FEEDER_PADDING_EN when it is defined for the build.
module tb_c1_feeder;
  localparam int IMG  = 4;
  localparam int OCH  = 2;
  localparam int TAIL = 4;
`ifdef C1_FEEDER_PADDING_EN
  localparam int P = (IMG + 2) * (IMG + 2);
`else
  localparam int P = IMG * IMG;
`endif
  localparam int EXP_DONE = 1 + OCH * (2 + P + 1 + TAIL);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   fails   = 0;
  bit   jitter  = 1'b0;
  int   ncyc    = 0;

  c1_feeder_if #(.N(16), .IMG_SIZE(IMG), .OUT_CH(OCH)) bus ();

  c1_feeder #(.N(16), .IMG_SIZE(IMG), .OUT_CH(OCH), .TAIL_CYCLES(TAIL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_w(input int ch);
    return (ch == 0) ? 16'd3 : 16'd5;
  endfunction
  function automatic logic [31:0] exp_b(input int ch);
    return (ch == 0) ? 32'd10 : 32'd20;
  endfunction
  function automatic logic [4:0] exp_s(input int ch);
    return (ch == 0) ? 5'd2 : 5'd1;
  endfunction
  function automatic logic [15:0] exp_din(input int p);
`ifdef C1_FEEDER_PADDING_EN
    int r, c;
    r = p / (IMG + 2);
    c = p % (IMG + 2);
    if (r == 0 || c == 0 || r == IMG + 1 || c == IMG + 1) return 16'd0;
    return 16'((r - 1) * IMG + c);
`else
    return 16'(p + 1);
`endif
  endfunction

  // RAM (RAM[i]=i+1, junk when not read) and ROM (random junk between reads when jitter is on)
  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    bus.fmap_rd_data <= bus.fmap_rd_en ? 16'(bus.fmap_rd_addr) + 16'd1 : 16'hBEEF;
    if (bus.param_rd_en) begin
      bus.weight_rd_data <= exp_w(int'(bus.param_rd_addr));
      bus.bias_rd_data   <= exp_b(int'(bus.param_rd_addr));
      bus.shift_rd_data  <= exp_s(int'(bus.param_rd_addr));
    end else if (jitter) begin
      bus.weight_rd_data <= 16'($urandom);
      bus.bias_rd_data   <= $urandom;
      bus.shift_rd_data  <= 5'($urandom);
    end
  end

  typedef struct {
    logic [15:0] din;
    logic [15:0] w;
    logic [31:0] b;
    logic [4:0]  s;
  } vrec_t;

  vrec_t       vq[$];
  int          rd_cnt   = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          bad_chg  = 0;
  logic [52:0] prm_prev = '0;
  logic        prd1 = 1'b0;
  logic        prd2 = 1'b0;

  // Parameters may only move two cycles after a ROM read
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.input_vld)
        vq.push_back(vrec_t'{din: bus.input_din, w: bus.weight_din, b: bus.bias_din, s: bus.shift_din});
      if (bus.fmap_rd_en) rd_cnt <= rd_cnt + 1;
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= ncyc;
      end
      if ({bus.weight_din, bus.bias_din, bus.shift_din} !== prm_prev && !prd2) bad_chg <= bad_chg + 1;
    end
    prm_prev <= {bus.weight_din, bus.bias_din, bus.shift_din};
    prd2     <= prd1;
    prd1     <= bus.param_rd_en;
  end

  task automatic start_run(output int s);
    @(negedge clk);
    bus.start = 1'b1;
    s = ncyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cnt > d0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] obs [11];
    string nm [11] = '{"busy", "done", "fmap_rd_en", "fmap_rd_addr", "param_rd_en", "param_rd_addr",
                       "input_vld", "input_din", "weight_din", "bias_din", "shift_din"};
    rst_n = 1'b0;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    obs = '{32'(bus.busy), 32'(bus.done), 32'(bus.fmap_rd_en), 32'(bus.fmap_rd_addr),
            32'(bus.param_rd_en), 32'(bus.param_rd_addr), 32'(bus.input_vld), 32'(bus.input_din),
            32'(bus.weight_din), bus.bias_din, 32'(bus.shift_din)};
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (obs[i] !== 32'd0) begin
        fails++;
        $display("FAIL reset_%s got %0h want 0", nm[i], obs[i]);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic(input string tag);
    int s, v0, r0, d0;
    bit ok;
    v0 = vq.size();
    r0 = rd_cnt;
    d0 = done_cnt;
    start_run(s);
    vectors++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL %s_busy_rise got %b want 1", tag, bus.busy); end
    wait_idle(d0, ok);
    vectors++;
    if (!ok) begin fails++; $display("FAIL %s_done_timeout got no done want done", tag); end
    vectors++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL %s_done_count got %0d want 1", tag, done_cnt - d0); end
    vectors++;
    if (done_cyc - s !== EXP_DONE) begin fails++; $display("FAIL %s_done_cycle got S+%0d want S+%0d", tag, done_cyc - s, EXP_DONE); end
    vectors++;
    if (vq.size() - v0 !== OCH * P) begin fails++; $display("FAIL %s_vld_count got %0d want %0d", tag, vq.size() - v0, OCH * P); end
    vectors++;
    if (rd_cnt - r0 !== OCH * IMG * IMG) begin fails++; $display("FAIL %s_rd_count got %0d want %0d", tag, rd_cnt - r0, OCH * IMG * IMG); end
    for (int k = 0; k < OCH * P && v0 + k < vq.size(); k++) begin
      vrec_t r;
      int ch;
      r  = vq[v0 + k];
      ch = k / P;
      vectors++;
      if (r.din !== exp_din(k % P)) begin fails++; $display("FAIL %s_din[%0d] got %0d want %0d", tag, k, r.din, exp_din(k % P)); end
      vectors++;
      if (r.w !== exp_w(ch)) begin fails++; $display("FAIL %s_weight[%0d] got %0d want %0d", tag, k, r.w, exp_w(ch)); end
      vectors++;
      if (r.b !== exp_b(ch)) begin fails++; $display("FAIL %s_bias[%0d] got %0d want %0d", tag, k, r.b, exp_b(ch)); end
      vectors++;
      if (r.s !== exp_s(ch)) begin fails++; $display("FAIL %s_shift[%0d] got %0d want %0d", tag, k, r.s, exp_s(ch)); end
    end
  endtask

  task automatic test_back_to_back;
    int s, d0;
    bit ok;
    d0 = done_cnt;
    start_run(s);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(d0, ok);
    repeat (30) @(negedge clk);
    vectors++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - d0); end
    vectors++;
    if (done_cyc - s !== EXP_DONE) begin fails++; $display("FAIL b2b_done_cycle got S+%0d want S+%0d", done_cyc - s, EXP_DONE); end
    vectors++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_after got %b want 0", bus.busy); end
  endtask

  task automatic test_start_in_done;
    int s, d0;
    bit seen;
    seen = 1'b0;
    d0 = done_cnt;
    start_run(s);
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin fails++; $display("FAIL done_start_seen got no done want done"); end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL done_start_busy got %b want 0", bus.busy); end
    repeat (5) @(negedge clk);
    vectors++;
    if (done_cnt - d0 !== 1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL done_start_rerun got done=%0d busy=%b want done=1 busy=0", done_cnt - d0, bus.busy);
    end
  endtask

  task automatic test_param_stability;
    int c0;
    c0 = bad_chg;
    jitter = 1'b1;
    test_basic("stab");
    jitter = 1'b0;
    vectors++;
    if (bad_chg - c0 !== 0) begin fails++; $display("FAIL stab_param_moves got %0d want 0", bad_chg - c0); end
  endtask

  task automatic test_reset_mid_stream;
    int s, v0;
    logic [31:0] obs [11];
    string nm [11] = '{"busy", "done", "fmap_rd_en", "fmap_rd_addr", "param_rd_en", "param_rd_addr",
                       "input_vld", "input_din", "weight_din", "bias_din", "shift_din"};
    v0 = vq.size();
    start_run(s);
    repeat (11) @(negedge clk);
    vectors++;
    if (bus.fmap_rd_en !== 1'b1) begin fails++; $display("FAIL midrst_streaming got %b want 1", bus.fmap_rd_en); end
    rst_n = 1'b0;
    #1;
    obs = '{32'(bus.busy), 32'(bus.done), 32'(bus.fmap_rd_en), 32'(bus.fmap_rd_addr),
            32'(bus.param_rd_en), 32'(bus.param_rd_addr), 32'(bus.input_vld), 32'(bus.input_din),
            32'(bus.weight_din), bus.bias_din, 32'(bus.shift_din)};
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (obs[i] !== 32'd0) begin
        fails++;
        $display("FAIL midrst_%s got %0h want 0", nm[i], obs[i]);
      end
    end
    vectors++;
    if (vq.size() <= v0) begin fails++; $display("FAIL midrst_vld_before got %0d want >%0d", vq.size(), v0); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = vq.size();
    repeat (5) @(negedge clk);
    vectors++;
    if (vq.size() !== v0) begin fails++; $display("FAIL midrst_stale_vld got %0d want 0", vq.size() - v0); end
    test_basic("restart");
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_basic("basic");
    test_back_to_back();
    test_start_in_done();
    test_param_stability();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
